// File: rtl/lut_cfg_pkg.sv
// Shared types and bit-stream geometry helpers for the configurable LUT array.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Each LUT occupies 2^k truth bits followed by one mode bit.
    function automatic int cfg_bits(input int k, input int n);
        return n * ((1 << k) + 1);
    endfunction

    function automatic int lut_base(input int j, input int k);
        return j * ((1 << k) + 1);
    endfunction

endpackage

// File: rtl/lut_k_config_array_lut_cell.sv
// One K-input LUT: truth table, mode bit and registered-output flop.
module lut_cell #(
    parameter int K  = 4,
    parameter int IW = K + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [IW-1:0] i_idx,
    input  logic          i_data,
    input  logic          i_ce,
    input  logic          i_clr,
    input  logic          i_eval,
    input  logic [K-1:0]  i_addr,
    output logic          o_out
);

    localparam int DEPTH = 1 << K;
    localparam logic [IW-1:0] MODE_IDX = IW'(DEPTH);

    logic [DEPTH-1:0] truth;
    logic             mode;
    logic             flop;

    // NOTE: the truth table is reset on purpose: unwritten bits must read 0,
    // so it cannot be left as reset-less storage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            truth <= '0;
            mode  <= 1'b0;
            flop  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            if (i_we) begin
                if (i_idx == MODE_IDX) begin
                    mode <= i_data;
                end else begin
                    truth[i_idx[K-1:0]] <= i_data;
                end
            end
            if (i_clr) begin
                flop <= 1'b0;
            end else if (i_eval && i_ce) begin
                flop <= truth[i_addr];
            end
        end
    end

    assign o_out = i_eval & (mode ? flop : truth[i_addr]);

endmodule

// File: rtl/lut_k_config_array.sv
// Array of N_LUT K-input LUTs loaded from a serial valid/ready bit-stream.
module lut_k_config_array
    import lut_cfg_pkg::*;
#(
    parameter int K     = 4,
    parameter int N_LUT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_start,
    input  logic               i_cfg_valid,
    input  logic               i_cfg_bit,
    output logic               o_cfg_ready,
    output logic               o_cfg_done,
    input  logic               i_ce,
    input  logic [N_LUT*K-1:0] i_lut_in,
    output logic [N_LUT-1:0]   o_lut_out
);

    localparam int CFG_BITS = cfg_bits(K, N_LUT);
    localparam int CW       = $clog2(CFG_BITS);
    localparam logic [CW-1:0] LAST = CW'(CFG_BITS - 1);
    localparam logic [CW-1:0] SPAN = CW'(1 << K);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          clr;
    logic          eval;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        clr         = 1'b0;
        o_cfg_ready = 1'b0;
        o_cfg_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                o_cfg_ready = 1'b1;
                // A restart wins over a bit offered in the same cycle.
                if (i_cfg_start) begin
                    cnt_d = '0;
                end else if (i_cfg_valid) begin
                    accept = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                o_cfg_done = 1'b1;
                if (i_cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign eval = (state_q == DONE);

    for (genvar j = 0; j < N_LUT; j++) begin : g_lut
        localparam logic [CW-1:0] BASE = CW'(lut_base(j, K));
        logic [CW-1:0] offset;
        logic          we;

        // Below BASE the subtraction wraps past SPAN, so one compare selects the segment.
        assign offset = cnt_q - BASE;
        assign we     = accept && (offset <= SPAN);

        lut_cell #(
            .K  (K),
            .IW (CW)
        ) u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (we),
            .i_idx   (offset),
            .i_data  (i_cfg_bit),
            .i_ce    (i_ce),
            .i_clr   (clr),
            .i_eval  (eval),
            .i_addr  (i_lut_in[j*K +: K]),
            .o_out   (o_lut_out[j])
        );
    end

endmodule

// File: doc/lut_k_config_array.md
Name: lut_k_config_array

Overview:
- Array of N_LUT independent K-input look-up tables.
- Configured through a serial bit-stream with a valid/ready handshake and a load state machine.
- Each LUT carries a mode bit that selects combinational or registered output.
- Successor to the single 4-input combinational LUT: adds clocked configuration, parametrised input width and LUT count, a per-LUT output register, and a done/abort protocol. It sits between the pin-level config interface and the user logic fabric.

Parameters:
- K, 4, inputs per LUT; truth table depth is 2^K bits; legal range 2..6.
- N_LUT, 2, number of LUTs in the array; legal range 1..8.
- CFG_BITS, N_LUT*(2**K+1), derived total bit-stream length; not overridable.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_cfg_start  input  1  one-cycle pulse: begin (or restart) configuration load
- i_cfg_valid  input  1  i_cfg_bit is valid this cycle
- i_cfg_bit  input  1  serial configuration bit
- o_cfg_ready  output  1  block accepts a config bit this cycle
- o_cfg_done  output  1  full bit-stream loaded; LUTs evaluating
- i_ce  input  1  clock enable for registered-mode output flops
- i_lut_in  input  N_LUT*K  LUT j address = i_lut_in[j*K +: K]
- o_lut_out  output  N_LUT  LUT j result on bit j

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; bit counter 0; all truth and mode bits 0.
  - output flops 0; o_cfg_ready=0, o_cfg_done=0, o_lut_out=0.
- States:
  - IDLE: o_cfg_ready=0, o_cfg_done=0, o_lut_out=0. i_cfg_start -> LOAD.
  - LOAD: o_cfg_ready=1. A bit is accepted when i_cfg_valid&&o_cfg_ready. Accepted bit n (counter value) is written to config position n, then the counter increments. Acceptance at n=CFG_BITS-1 -> DONE next cycle, counter cleared.
  - DONE: o_cfg_done=1, o_cfg_ready=0, LUTs evaluate. i_cfg_start -> LOAD.
- Bit-stream order, LUT 0 first:
  - For LUT j, bits j*(2^K+1) .. j*(2^K+1)+2^K-1 are truth[j][0..2^K-1], in increasing address order.
  - The following bit is mode[j]: 0=combinational, 1=registered.
- Evaluation (DONE only):
  - mode 0: o_lut_out[j] = truth[j][addr_j] combinationally, zero latency.
  - mode 1: flop_j <= truth[j][addr_j] on the i_clk rising edge when i_ce=1; holds when i_ce=0; o_lut_out[j]=flop_j, latency 1 cycle.
- Outside DONE, o_lut_out is forced to 0 regardless of mode.
- i_cfg_start in LOAD (abort/restart):
  - counter returns to 0 and state stays LOAD.
  - A bit presented in the same cycle is NOT accepted.
  - Previously written config bits persist until overwritten.
- i_cfg_start in DONE:
  - -> LOAD; all output flops cleared to 0 the same edge.
  - Config memory is retained until overwritten.
- i_cfg_valid while o_cfg_ready=0 is ignored; no error is raised.
- i_cfg_start in IDLE together with i_cfg_valid: the start is taken and the bit is not accepted. The first acceptable bit is on the following cycle.
- Reset mid-LOAD: everything returns to reset values; partial configuration is discarded.
- Counter width is $clog2(CFG_BITS); it never wraps, because leaving LOAD at CFG_BITS-1 resets it.

Decomposition:
- Package lut_cfg_pkg:
  - state enum {IDLE, LOAD, DONE}, 2-bit encoding.
  - function cfg_bits(K,N) returning N*(2**K+1).
  - function lut_base(j,K) returning the first bit index of LUT j.
- Sub-module lut_cell (parameter K):
  - holds truth[2^K], mode bit and output flop.
  - ports: i_clk, i_rst_n, write enable + bit index + data, i_ce, i_clr, i_eval, address, output.
  - Top-level instantiates N_LUT of them with a generate loop and owns the FSM and counter.

Test Plan (K=4, N_LUT=2, CFG_BITS=34):
- Reset then idle: i_rst_n low -> o_lut_out=2'b00, o_cfg_ready=0, o_cfg_done=0; toggling i_lut_in keeps outputs 0.
- Full load: LUT0 truth 16'h6996 (4-input XOR), mode0=0; LUT1 truth 16'h8000 (AND4), mode1=1 -> o_cfg_done=1 one cycle after the 34th accepted bit.
  - i_lut_in=8'hF7: o_lut_out[0]=1 immediately.
  - i_lut_in=8'hF0: o_lut_out[0]=0 same cycle; o_lut_out[1]=1 one edge after i_lut_in[7:4]=4'hF with i_ce=1.
- Handshake gaps: drop i_cfg_valid randomly for 1-5 cycles during LOAD -> final configuration identical to the gapless case; exactly 34 bits consumed.
- Abort: after 20 bits assert i_cfg_start with i_cfg_valid=1 -> that bit is not taken, counter=0; a fresh 34-bit stream gives the new function.
- i_ce hold: LUT1 registered output=1; set i_ce=0 and change address to 4'h0 -> o_lut_out[1] stays 1 until i_ce=1 returns, then 0 after one edge.
- Async reset mid-LOAD (bit 10): o_cfg_ready falls without a clock edge; after release, DONE is reached only after a new start plus 34 bits, with unwritten bits reading 0.
